pmod_als_responder: RTL



---
 rtl/pmod_als_responder.sv | 125 ++++++++++++
 1 files changed

// File: rtl/pmod_als_responder.sv
// pmod_als_responder: SPI mode-0 responder emulating the PmodALS ADC frame, oversampled on Clock
module pmod_als_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = 16,
    parameter int LEAD_ZEROS  = 3
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [7:0]            sample,
    input  logic                  load,
    input  logic                  SCLK,
    input  logic                  CS,
    input  logic                  MOSI,
    output logic                  MISO,
    output logic                  busy,
    output logic [FRAME_BITS-1:0] rx_data,
    output logic                  frame_done,
    output logic                  frame_err
);
    localparam int TAIL = FRAME_BITS - LEAD_ZEROS - 8;
    localparam int CW   = $clog2(FRAME_BITS + 2);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                  state;
    logic [SYNC_STAGES-1:0]  sclk_sync, cs_sync, mosi_sync;
    logic                    sclk_d, cs_d;
    logic                    sclk_s, cs_s, mosi_s;
    logic                    sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic [FRAME_BITS-1:0]   tx_sr, rx_sr, tx_init;
    logic [7:0]              serve, pending;
    logic                    pend_v;
    logic [CW-1:0]           bit_cnt;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_fall   = ~cs_s & cs_d;
    assign cs_rise   = cs_s & ~cs_d;
    assign tx_init   = FRAME_BITS'(serve) << TAIL;
    assign MISO      = tx_sr[FRAME_BITS-1];

    // Pin synchronizers plus one delay flop each for edge detection; CS idles high
    always_ff @(posedge Clock) begin
        if (Reset) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
        end
    end

    // Frame FSM: serve register, pending load, tx/rx shifting and end-of-frame reporting
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= IDLE;
            tx_sr      <= '0;
            rx_sr      <= '0;
            rx_data    <= '0;
            serve      <= '0;
            pending    <= '0;
            pend_v     <= 1'b0;
            bit_cnt    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state   <= SHIFT;
                        tx_sr   <= tx_init;
                        bit_cnt <= '0;
                        busy    <= 1'b1;
                        if (load) begin
                            pending <= sample;
                            pend_v  <= 1'b1;
                        end
                    end else if (load) begin
                        serve <= sample;
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        tx_sr  <= '0;
                        pend_v <= 1'b0;
                        serve  <= load ? sample : pend_v ? pending : serve;
                        if (bit_cnt == CW'(FRAME_BITS)) begin
                            rx_data    <= rx_sr;
                            frame_done <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        if (load) begin
                            pending <= sample;
                            pend_v  <= 1'b1;
                        end
                        if (sclk_rise) begin
                            rx_sr <= {rx_sr[FRAME_BITS-2:0], mosi_s};
                            if (bit_cnt != CW'(FRAME_BITS + 1))
                                bit_cnt <= bit_cnt + 1'b1;
                        end
                        if (sclk_fall)
                            tx_sr <= {tx_sr[FRAME_BITS-2:0], 1'b0};
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
